// File: rtl/log_ram_pkg.sv
// Shared constants for the sample capture buffer: host opcodes, command word
// and status word field positions, and the controller state encoding.
package log_ram_pkg;

  localparam logic [7:0] OP_CTRL  = 8'h00;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h04;
  localparam logic [7:0] OP_RDCLR = 8'h05;

  localparam int unsigned CMD_VALID_BIT = 23;
  localparam int unsigned OPCODE_LSB    = 24;
  localparam int unsigned ARG_LSB       = 8;
  localparam int unsigned FLAG0_BIT     = 0;

  localparam int unsigned GPI_DONE_BIT  = 31;
  localparam int unsigned GPI_BUSY_BIT  = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOGGING = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/log_ram_sdp.sv
// Simple dual-port inferred block RAM: one write port and one registered
// read port with 1-cycle latency; read data holds between read enables.
module log_ram_sdp #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned RAM_DEPTH = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset so the status word reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/log_ram_ctrl.sv
// Capture buffer: logs DSP samples into block RAM on host START and serves
// them back one word per READ strobe. Optional decimation: LOG_DECIM_EN.
module log_ram_ctrl
  import log_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_DEPTH = 32768,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clockdsp,
  input  logic              i_reset,
  input  logic [31:0]       i_gpo0,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic [31:0]       o_gpi0,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  logic [31:0]       sync1_q, sync2_q, prev_q;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [1:0]        stat_q, stat_d;
  logic              we;
  logic              take;
  logic [DATA_W-1:0] rdata;

  logic       cmd_new, is_soft, is_start, is_read, is_rdclr;
  logic [7:0] opcode;

`ifdef LOG_DECIM_EN
  logic [7:0] dec_n_q, dec_n_d;
  logic [7:0] dec_cnt_q, dec_cnt_d;
`endif

  // A command fires once: only in the cycle the synchronized word changes.
  always_comb begin
    opcode   = sync2_q[OPCODE_LSB +: 8];
    cmd_new  = sync2_q[CMD_VALID_BIT] && (sync2_q != prev_q);
    is_soft  = cmd_new && (opcode == OP_CTRL) && !sync2_q[FLAG0_BIT];
    is_start = cmd_new && (opcode == OP_START);
    is_read  = cmd_new && (opcode == OP_READ) && sync2_q[FLAG0_BIT] && !prev_q[FLAG0_BIT];
    is_rdclr = cmd_new && (opcode == OP_RDCLR);
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    we        = 1'b0;
    take      = 1'b1;
`ifdef LOG_DECIM_EN
    dec_n_d   = dec_n_q;
    dec_cnt_d = dec_cnt_q;
    take      = (dec_cnt_q == '0);
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (is_start) begin
          state_d  = LOGGING;
          wr_ptr_d = '0;
`ifdef LOG_DECIM_EN
          dec_n_d   = sync2_q[ARG_LSB +: 8];
          dec_cnt_d = '0;
`endif
        end else if (is_read) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_ptr_q;
          rd_ptr_d  = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end
      end
      LOGGING: begin
        if (i_data_valid) begin
`ifdef LOG_DECIM_EN
          dec_cnt_d = (dec_cnt_q == dec_n_q) ? '0 : dec_cnt_q + 1'b1;
`endif
          if (take) begin
            we = 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              wr_ptr_d = '0;
              state_d  = DONE;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (is_rdclr) rd_ptr_d = '0;

    // Soft reset wins over everything, including a write landing this cycle.
    if (is_soft) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      we       = 1'b0;
`ifdef LOG_DECIM_EN
      dec_cnt_d = '0;
`endif
    end

    stat_d = {state_q == DONE, state_q == LOGGING};
  end

  always_ff @(posedge clockdsp or posedge i_reset) begin
    if (i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      stat_q    <= '0;
`ifdef LOG_DECIM_EN
      dec_n_q   <= '0;
      dec_cnt_q <= '0;
`endif
    end else begin
      sync1_q   <= i_gpo0;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      stat_q    <= stat_d;
`ifdef LOG_DECIM_EN
      dec_n_q   <= dec_n_d;
      dec_cnt_q <= dec_cnt_d;
`endif
    end
  end

  log_ram_sdp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_ram (
    .clk  (clockdsp),
    .rst  (i_reset),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(i_data),
    .re   (rd_en_q),
    .raddr(rd_addr_q),
    .rdata(rdata)
  );

  always_comb begin
    o_gpi0               = '0;
    o_gpi0[DATA_W-1:0]   = rdata;
    o_gpi0[GPI_DONE_BIT] = stat_q[1];
    o_gpi0[GPI_BUSY_BIT] = stat_q[0];
  end

  assign o_busy = (state_q == LOGGING);
  assign o_done = (state_q == DONE);

endmodule
